// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the FSM state encoding, default bus widths and one-hot grant codes.
package wb_arb_pkg;

  localparam int ADDR_W_DEF = 36;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  function automatic logic [1:0] grant_of(input logic owner);
    return owner ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of both master ports, the shared slave port and arbiter status.
// The slave modport is the arbiter's view; master is the surrounding system.
interface wb_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
);

  logic [ADDR_WIDTH-1:0]   m0_adr_i, m1_adr_i;
  logic [DATA_WIDTH-1:0]   m0_dat_i, m1_dat_i;
  logic [DATA_WIDTH-1:0]   m0_dat_o, m1_dat_o;
  logic                    m0_we_i,  m1_we_i;
  logic [DATA_WIDTH/8-1:0] m0_sel_i, m1_sel_i;
  logic                    m0_stb_i, m1_stb_i;
  logic                    m0_cyc_i, m1_cyc_i;
  logic                    m0_ack_o, m1_ack_o;
  logic                    m0_err_o, m1_err_o;

  logic [ADDR_WIDTH-1:0]   s_adr_o;
  logic [DATA_WIDTH-1:0]   s_dat_o;
  logic                    s_we_o;
  logic [DATA_WIDTH/8-1:0] s_sel_o;
  logic                    s_stb_o;
  logic                    s_cyc_o;
  logic [DATA_WIDTH-1:0]   s_dat_i;
  logic                    s_ack_i;
  logic                    s_err_i;

  logic [1:0]              grant_o;
  logic                    timeout_o;

  modport slave (
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i,
           m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
           s_dat_i, s_ack_i, s_err_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
           grant_o, timeout_o
  );

  modport master (
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i,
           m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
           s_dat_i, s_ack_i, s_err_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
           grant_o, timeout_o
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Wait-state counter: counts enabled cycles, saturates at TIMEOUT, clear wins.
// expired_o is combinational from the count; TIMEOUT=0 never expires.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone classic arbiter with bus lock and stuck-slave watchdog.
// Grant one cycle after cyc; slave signals and ack/err are combinational from the registered owner.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         nreset,
  wb_arbiter_if.slave  bus
);

  arb_state_e state_q;
  logic       owner_q;
  logic       last_owner_q;
  logic [1:0] grant_q;

  logic own_cyc, own_stb, oth_cyc, req_owner, in_own, live;
  logic wd_en, wd_clr, wd_expired, wd_fire;

  logic [ADDR_WIDTH-1:0]   adr_mux;
  logic [DATA_WIDTH-1:0]   dat_mux;
  logic [DATA_WIDTH/8-1:0] sel_mux;
  logic                    we_mux;

  assign own_cyc = owner_q ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign own_stb = owner_q ? bus.m1_stb_i : bus.m0_stb_i;
  assign oth_cyc = owner_q ? bus.m0_cyc_i : bus.m1_cyc_i;
  // On a tie the master that did not own the bus last wins.
  assign req_owner = (bus.m0_cyc_i && bus.m1_cyc_i) ? ~last_owner_q : bus.m1_cyc_i;
  assign in_own  = (state_q == ST_OWN);

  assign wd_en   = in_own & own_cyc & own_stb & ~bus.s_ack_i & ~bus.s_err_i;
  assign wd_clr  = ~wd_en;
  assign wd_fire = wd_en & wd_expired;

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .nreset    (nreset),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  assign adr_mux = owner_q ? bus.m1_adr_i : bus.m0_adr_i;
  assign dat_mux = owner_q ? bus.m1_dat_i : bus.m0_dat_i;
  assign sel_mux = owner_q ? bus.m1_sel_i : bus.m0_sel_i;
  assign we_mux  = owner_q ? bus.m1_we_i  : bus.m0_we_i;

  // The abort cycle already drops the slave side so the slave sees the cycle end.
  assign live        = in_own & own_cyc & ~wd_fire;
  assign bus.s_cyc_o = live;
  assign bus.s_stb_o = live & own_stb;
  assign bus.s_we_o  = live & we_mux;
  assign bus.s_adr_o = live ? adr_mux : '0;
  assign bus.s_dat_o = live ? dat_mux : '0;
  assign bus.s_sel_o = live ? sel_mux : '0;

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_ack_o = in_own & ~owner_q & bus.s_ack_i;
  assign bus.m1_ack_o = in_own &  owner_q & bus.s_ack_i;
  assign bus.m0_err_o = in_own & ~owner_q & (bus.s_err_i | wd_fire);
  assign bus.m1_err_o = in_own &  owner_q & (bus.s_err_i | wd_fire);
  assign bus.timeout_o = wd_fire;
  assign bus.grant_o   = grant_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      grant_q      <= GNT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.m0_cyc_i || bus.m1_cyc_i) begin
            state_q <= ST_OWN;
            owner_q <= req_owner;
            grant_q <= grant_of(req_owner);
          end
        end
        ST_OWN: begin
          if (wd_fire) begin
            state_q <= ST_ABORT;
          end else if (!own_cyc) begin
            last_owner_q <= owner_q;
            if (oth_cyc) begin
              owner_q <= ~owner_q;
              grant_q <= grant_of(~owner_q);
            end else begin
              state_q <= ST_IDLE;
              grant_q <= GNT_NONE;
            end
          end
        end
        ST_ABORT: begin
          if (!own_cyc) begin
            last_owner_q <= owner_q;
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master Wishbone classic arbiter that shares one slave port (wb_ram, SDRAM bridge, register file) between limb_interface (master 0) and a second on-chip master (master 1, e.g. DMA).
- Round-robin grant with per-owner bus lock for as long as the owner holds cyc.
- Watchdog terminates with err any cycle the slave never acknowledges, so a stuck slave cannot hang the LIMB bus (limb_nwait).

Parameters:
- ADDR_WIDTH, 36, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; SEL width = DATA_WIDTH/8.
- TIMEOUT, 255, clk cycles stb may wait for ack/err before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nreset  in  1  asynchronous active-low reset.
- m0_adr_i / m1_adr_i  in  ADDR_WIDTH  master address.
- m0_dat_i / m1_dat_i  in  DATA_WIDTH  master write data.
- m0_dat_o / m1_dat_o  out  DATA_WIDTH  read data (s_dat_i fanned out to both).
- m0_we_i / m1_we_i  in  1  write enable.
- m0_sel_i / m1_sel_i  in  DATA_WIDTH/8  byte selects.
- m0_stb_i / m1_stb_i  in  1  strobe.
- m0_cyc_i / m1_cyc_i  in  1  cycle / bus request.
- m0_ack_o / m1_ack_o  out  1  ack, owner only.
- m0_err_o / m1_err_o  out  1  err, owner only (slave err or timeout).
- s_adr_o  out  ADDR_WIDTH; s_dat_o  out  DATA_WIDTH; s_we_o  out  1; s_sel_o  out  DATA_WIDTH/8; s_stb_o  out  1; s_cyc_o  out  1  slave-side muxed signals.
- s_dat_i  in  DATA_WIDTH; s_ack_i  in  1; s_err_i  in  1  slave responses.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (nreset low, async): state IDLE, grant_o=00, last_owner=1, watchdog=0. s_cyc_o, s_stb_o, s_we_o, all ack/err, timeout_o = 0. s_adr_o, s_dat_o, s_sel_o = 0.
- States: IDLE, OWN, ABORT. Owner is a registered 1-bit value.
- IDLE: with no cyc asserted, stay. With one cyc asserted, grant that master at the next edge. With both asserted, grant the master != last_owner; first tie after reset goes to m0.
- OWN:
  - s_cyc_o = owner cyc; s_stb_o = owner stb; adr/dat/we/sel muxed from owner, all combinational from the registered owner.
  - s_ack_i/s_err_i route combinationally to the owner only; the non-owner's ack/err stays 0.
  - Latency: cyc asserted in cycle n → s_cyc_o high in n+1; ack returns to the master in the same cycle as s_ack_i.
- Release: in OWN, when owner cyc is low at an edge, last_owner <= owner. If the other master's cyc is high, grant it directly (switch). Otherwise go to IDLE.
- Lock: owner keeps the grant across any number of stb cycles while cyc stays high. A non-owner request waits.
- Watchdog:
  - Counter increments each cycle in OWN with s_stb_o=1 and s_ack_i=s_err_i=0.
  - Clears on ack, err, stb low or grant change.
  - When it reaches TIMEOUT: for one cycle force owner err_o=1 and timeout_o=1, and drop s_cyc_o/s_stb_o; next state ABORT.
- ABORT: s_cyc_o=s_stb_o=0; late s_ack_i is ignored and not forwarded. Stay until owner cyc low, then last_owner <= owner and go to IDLE.
- Simultaneous events:
  - s_ack_i and s_err_i both high: forward both; the master treats it as err.
  - Ack in the same cycle the count reaches TIMEOUT: the ack wins and there is no abort.
- Reset mid-transfer: immediate deassertion of s_cyc_o/s_stb_o. The master must restart.

Decomposition:
- Package wb_arb_pkg: state encoding (IDLE/OWN/ABORT), default width constants (36/32), grant one-hot constants.
- One sub-module, wb_arb_watchdog: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT, width $clog2(TIMEOUT+1).

Test Plan:
- m0 alone writes 0xDEADBEEF to adr 0x4 against wb_ram → s_cyc_o high one cycle after m0_cyc_i; m0_ack_o mirrors s_ack_i; m1_ack_o stays 0; readback returns 0xDEADBEEF.
- Both cyc asserted in the same cycle after reset, each releasing after one transfer → grant sequence 01,10,01,10; no master starves.
- m1 holds cyc for 4 back-to-back stb transfers while m0 requests → grant stays 10 until m1 drops cyc, then switches directly to 01 with no IDLE cycle.
- TIMEOUT=8, slave never acks → m0_err_o and timeout_o pulse exactly on the 9th cycle of stb, s_cyc_o drops that cycle, state ABORT until m0 drops cyc.
- Slave acks on the cycle the counter reaches TIMEOUT → ack forwarded; err_o and timeout_o stay 0.
- nreset pulled low during an m1 read wait state → s_cyc_o, s_stb_o, grant_o go 0 immediately; after release, the first tie is granted to m0.
